aes_round_engine: RTL

Iterative, parametrised AES round engine: one round per cycle, encrypt or decrypt selectable per block, AES-128/192/256 selected by parameter. It sits between the key-schedule block, which serves round keys over a request/valid handshake, and the mode/stream logic, which connects over valid/ready. It adds input/output flow control, a stall-tolerant round-key interface, decryption and abort to the single-shot encrypt-only cipher.

---
 rtl/aes_round_engine.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/aes_round_engine.sv
// Iterative AES round engine: one round per accepted round key, encrypt or
// straight inverse cipher per block, key length chosen by NK (4/6/8 words).
// Byte i of a 128-bit block lives at [127-8*i -: 8] (row i%4, column i/4).
module aes_round_engine #(
  parameter int NK         = 4,
  parameter int NR         = NK + 6,
  parameter bit ENABLE_DEC = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         abort,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_decrypt,
  output logic         rk_req,
  output logic [3:0]   rk_idx,
  input  logic         rk_valid,
  input  logic [127:0] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_decrypt,
  output logic         busy
);

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // The inverse table is derived from the forward one at elaboration so the
  // two can never disagree.
  function automatic logic [2047:0] build_inv(input logic [2047:0] t);
    logic [2047:0] inv;
    inv = '0;
    for (int i = 0; i < 256; i++)
      inv[2047 - 8*int'(t[2047 - 8*i -: 8]) -: 8] = 8'(i);
    return inv;
  endfunction

  localparam logic [2047:0] INV_SBOX_TBL = build_inv(SBOX_TBL);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a small constant (2..14) with shift-and-add over GF(2^8).
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++)
      o[127 - 8*i -: 8] = inv ? INV_SBOX_TBL[2047 - 8*int'(s[127 - 8*i -: 8]) -: 8]
                              : SBOX_TBL[2047 - 8*int'(s[127 - 8*i -: 8]) -: 8];
    return o;
  endfunction

  // Row r rotates left by r columns (right by r for the inverse).
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(r + 4*c) -: 8] = inv ? s[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8]
                                        : s[127 - 8*(r + 4*((c + r) % 4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      if (inv) begin
        o[127 - 32*c -: 8] = gmul(a0, 4'd14) ^ gmul(a1, 4'd11) ^ gmul(a2, 4'd13) ^ gmul(a3, 4'd9);
        o[119 - 32*c -: 8] = gmul(a0, 4'd9) ^ gmul(a1, 4'd14) ^ gmul(a2, 4'd11) ^ gmul(a3, 4'd13);
        o[111 - 32*c -: 8] = gmul(a0, 4'd13) ^ gmul(a1, 4'd9) ^ gmul(a2, 4'd14) ^ gmul(a3, 4'd11);
        o[103 - 32*c -: 8] = gmul(a0, 4'd11) ^ gmul(a1, 4'd13) ^ gmul(a2, 4'd9) ^ gmul(a3, 4'd14);
      end else begin
        o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
    end
    return o;
  endfunction

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t       state_q, state_d;
  logic [127:0] st_q;
  logic [127:0] round_out, fwd_t, inv_t;
  logic [3:0]   r_q;
  logic         mode_q;
  logic         rdy_q;
  logic         accept, rk_take, last_round;

  assign in_ready    = rdy_q && (state_q == IDLE);
  assign accept      = in_valid && in_ready;
  assign rk_req      = (state_q == ROUND);
  assign rk_take     = rk_req && rk_valid;
  assign last_round  = (r_q == 4'(NR));
  assign rk_idx      = !rk_req ? 4'd0 : (mode_q ? 4'(NR) - r_q : r_q);
  assign out_valid   = (state_q == DONE);
  assign out_data    = st_q;
  assign out_decrypt = mode_q;
  assign busy        = (state_q != IDLE);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ROUND;
      ROUND:   if (rk_take && last_round) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // One cipher round on the current state with the key being presented.
  always_comb begin
    fwd_t     = shift_rows(sub_bytes(st_q, 1'b0), 1'b0);
    inv_t     = sub_bytes(shift_rows(st_q, 1'b1), 1'b1) ^ rk_data;
    round_out = st_q ^ rk_data;
    if (r_q != 4'd0) begin
      if (ENABLE_DEC && mode_q)
        round_out = last_round ? inv_t : mix_columns(inv_t, 1'b1);
      else
        round_out = (last_round ? fwd_t : mix_columns(fwd_t, 1'b0)) ^ rk_data;
    end
  end

  // Block state, round counter and mode; registers hold on key stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= '0;
      r_q    <= '0;
      mode_q <= 1'b0;
      rdy_q  <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (abort) begin
        st_q   <= '0;
        r_q    <= '0;
        mode_q <= 1'b0;
      end else if (accept) begin
        st_q   <= in_data;
        r_q    <= '0;
        mode_q <= ENABLE_DEC && in_decrypt;
      end else if (rk_take) begin
        st_q <= round_out;
        if (!last_round) r_q <= r_q + 4'd1;
      end
    end
  end

endmodule
